// File: rtl/timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_ctrl_pkg
//  Description : Shared opcodes, FSM state and mode encodings for timer_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_ctrl_pkg;

  localparam logic [2:0] c_op_nop            = 3'd0;
  localparam logic [2:0] c_op_load_cnt       = 3'd1;
  localparam logic [2:0] c_op_load_cmp       = 3'd2;
  localparam logic [2:0] c_op_load_pre       = 3'd3;
  localparam logic [2:0] c_op_start_oneshot  = 3'd4;
  localparam logic [2:0] c_op_start_periodic = 3'd5;
  localparam logic [2:0] c_op_pause          = 3'd6;
  localparam logic [2:0] c_op_stop           = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_t;

endpackage
`default_nettype wire

// File: rtl/timer_core.sv
`default_nettype none
// ============================================================================
//  Module      : timer_core
//  Description : Counting datapath: clear / load / increment with a
//                combinational compare against the match value.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic             tick,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] cmp,
  output logic [WIDTH-1:0] cnt,
  output logic             at_cmp
);

  logic [WIDTH-1:0] r_cnt;

  // Count register: clear beats load beats increment.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (tick) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt    = r_cnt;
  assign at_cmp = (r_cnt == cmp);

endmodule
`default_nettype wire

// File: rtl/timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : timer_ctrl
//  Description : Command-driven timer controller (one-shot / periodic,
//                pause/resume, compare match). Optional prescaler is built
//                when TIMER_CTRL_PRESCALER_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             match_o,
  output logic [1:0]       state_o,
  output logic             err_o
);

  state_t           r_state, w_state_nxt;
  mode_t            r_mode, w_mode_nxt;
  logic             r_pend;
  logic [2:0]       r_pend_cmd;
  logic [WIDTH-1:0] r_pend_data;
  logic [WIDTH-1:0] r_cmp;
  logic             r_err, w_err_nxt;
  logic             r_match, w_match_nxt;
  logic             w_tick;
  logic             w_at_cmp;
  logic             w_core_tick, w_core_clr, w_core_load;
  logic             w_cmp_wr;
  logic [WIDTH-1:0] w_cnt;

`ifdef TIMER_CTRL_PRESCALER_EN
  logic [WIDTH-1:0] r_pre, r_pre_cnt;
  logic             w_pre_wr, w_pre_clr;

  assign w_tick = (r_state == ST_RUN) && (r_pre_cnt == r_pre);

  // Prescaler: wraps at pre while running, holds otherwise, cleared on restart.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      r_pre     <= '0;
      r_pre_cnt <= '0;
    end else begin
      if (w_pre_wr) begin
        r_pre <= r_pend_data;
      end
      if (w_pre_clr) begin
        r_pre_cnt <= '0;
      end else if (r_state == ST_RUN) begin
        r_pre_cnt <= (r_pre_cnt == r_pre) ? '0 : r_pre_cnt + 1'b1;
      end
    end
  end
`else
  assign w_tick = (r_state == ST_RUN);
`endif

  // Next-state and datapath control; an executing command masks the tick.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_err_nxt   = r_err;
    w_match_nxt = 1'b0;
    w_core_tick = 1'b0;
    w_core_clr  = 1'b0;
    w_core_load = 1'b0;
    w_cmp_wr    = 1'b0;
`ifdef TIMER_CTRL_PRESCALER_EN
    w_pre_wr    = 1'b0;
    w_pre_clr   = 1'b0;
`endif
    if (r_pend) begin
      case (r_pend_cmd)
        c_op_load_cnt: begin
          if (r_state == ST_RUN) w_err_nxt = 1'b1;
          else                   w_core_load = 1'b1;
        end
        c_op_load_cmp: w_cmp_wr = 1'b1;
        c_op_load_pre: begin
`ifdef TIMER_CTRL_PRESCALER_EN
          w_pre_wr  = 1'b1;
          w_pre_clr = 1'b1;
`endif
        end
        c_op_start_oneshot, c_op_start_periodic: begin
          w_mode_nxt  = (r_pend_cmd == c_op_start_periodic) ? MODE_PERIODIC : MODE_ONESHOT;
          w_core_clr  = (r_state == ST_DONE);
          w_state_nxt = ST_RUN;
`ifdef TIMER_CTRL_PRESCALER_EN
          w_pre_clr   = 1'b1;
`endif
        end
        c_op_pause: begin
          if (r_state == ST_RUN) w_state_nxt = ST_PAUSE;
        end
        c_op_stop: begin
          w_state_nxt = ST_IDLE;
          w_core_clr  = 1'b1;
          w_err_nxt   = 1'b0;
`ifdef TIMER_CTRL_PRESCALER_EN
          w_pre_clr   = 1'b1;
`endif
        end
        default: ;
      endcase
    end else if (w_tick) begin
      if (w_at_cmp) begin
        w_match_nxt = 1'b1;
        if (r_mode == MODE_PERIODIC) w_core_clr  = 1'b1;
        else                         w_state_nxt = ST_DONE;
      end else begin
        w_core_tick = 1'b1;
      end
    end
  end

  // State, command register and control flags.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_ONESHOT;
      r_pend      <= 1'b0;
      r_pend_cmd  <= c_op_nop;
      r_pend_data <= '0;
      r_cmp       <= '0;
      r_err       <= 1'b0;
      r_match     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_err   <= w_err_nxt;
      r_match <= w_match_nxt;
      r_pend  <= cmd_valid_i && !r_pend;
      if (cmd_valid_i && !r_pend) begin
        r_pend_cmd  <= cmd_i;
        r_pend_data <= data_i;
      end
      if (w_cmp_wr) begin
        r_cmp <= r_pend_data;
      end
    end
  end

  timer_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk_i    (clk_i),
    .nrst_i   (nrst_i),
    .tick     (w_core_tick),
    .clr      (w_core_clr),
    .load     (w_core_load),
    .load_val (r_pend_data),
    .cmp      (r_cmp),
    .cnt      (w_cnt),
    .at_cmp   (w_at_cmp)
  );

  assign cmd_ready_o = !r_pend;
  assign cnt_o       = w_cnt;
  assign match_o     = r_match;
  assign state_o     = r_state;
  assign err_o       = r_err;

endmodule
`default_nettype wire
